uart_memory_client: RTL and testbench
=====================================

# uart_memory_client

- Host-side initiator for the UART memory protocol.
- Accepts one read or write request at a time on a valid/ready port.
- Serializes each request into command, address-high, address-low and (for writes) data bytes toward the UART transmitter.
- For reads, captures the single reply byte from the UART receiver and returns it on a response port.

## Interface
Parameters:
- CMD_WRITE, default `COMMAND_WRITE: opcode byte for writes.
- CMD_READ, default `COMMAND_READ: opcode byte for reads.
- TIMEOUT_CYCLES, default 1000000: read-reply watchdog limit. Used only with UART_MEMORY_CLIENT_TIMEOUT_EN.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; request accepted on req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  memory address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse; transaction complete.
- rsp_rdata  out  8  read data; held until the next read completes.
- rsp_timeout  out  1  qualifies rsp_valid; read reply never arrived.
- transmit  out  1  one-cycle pulse; tx_byte is valid in that cycle.
- tx_byte  out  8  byte to the UART transmitter.
- tx_busy  in  1  UART transmitter busy.
- received  in  1  one-cycle pulse from the UART receiver.
- rx_byte  in  8  received byte, valid with received.

## Operation
- FSM states: IDLE, SEND_CMD, SEND_AHI, SEND_ALO, SEND_DATA, WAIT_RSP.
- IDLE: req_ready=1. On acceptance, latch req_write, req_addr and req_wdata, then go to SEND_CMD.
- Each SEND state issues one byte: transmit=1 with tx_byte = opcode / req_addr[15:8] / req_addr[7:0] / wdata.
- A byte is issued only when tx_busy=0 and the guard flag is clear.
  - Issuing a byte sets the guard for exactly one cycle, covering the transmitter's busy-rise latency.
  - While tx_busy=1, the FSM stalls and transmit stays 0.
- Write path: SEND_ALO → SEND_DATA. After the data byte issues, rsp_valid=1 and rsp_timeout=0; return to IDLE.
- Read path: SEND_ALO → WAIT_RSP.
  - First received pulse: rsp_rdata=rx_byte, rsp_valid=1; return to IDLE.
- received is ignored in every state except WAIT_RSP (stray bytes are dropped).
- Request inputs are ignored while req_ready=0.

## Timing
- Reset values: req_ready=1; rsp_valid, rsp_timeout, transmit = 0; tx_byte=8'h00; rsp_rdata=8'h00; state=IDLE; guard clear; timeout counter 0.
- Reset asserted mid-transaction:
  - Immediate abort to IDLE.
  - No rsp_valid for the aborted request.
  - Bytes already sent are not recalled; the system resets the responder too.
- Latency with tx_busy held at 0 and acceptance at edge 0:
  - Write: transmit at cycles 1, 3, 5, 7; rsp_valid at cycle 8; req_ready=1 at cycle 8.
  - Read: transmit at cycles 1, 3, 5; WAIT_RSP from cycle 6. A received at cycle N gives rsp_valid at cycle N+1.
- tx_busy high: each byte issues on the first cycle after the guard clears with tx_busy sampled low.
- req_ready is 0 from the cycle after acceptance until the rsp_valid cycle.
- A new request may be accepted on the cycle rsp_valid is high.

## Configuration
- Macro UART_MEMORY_CLIENT_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES with no received pulse: rsp_valid=1, rsp_timeout=1, rsp_rdata=8'h00; return to IDLE.
  - If received and expiry coincide, the byte wins and rsp_timeout=0.
  - The counter clears on leaving WAIT_RSP.
- Undefined: no counter; WAIT_RSP waits indefinitely; rsp_timeout is tied 0.

## Test plan
- Write addr 16'h0ECD, data 8'h42, tx_busy=0 → tx_byte sequence CMD_WRITE, 0E, CD, 42 at cycles 1/3/5/7; rsp_valid at cycle 8 with rsp_timeout=0.
- Read addr 16'h0A10, then inject received with rx_byte=8'h44 in WAIT_RSP → tx_byte sequence CMD_READ, 0A, 10; rsp_valid next cycle with rsp_rdata=8'h44.
- Read addr 16'h0ECD with tx_busy high for 10 cycles after each transmit → no transmit while busy; bytes stay in order and unduplicated; reply 8'h42 returned.
- Inject received 8'hAA while in IDLE and SEND_AHI → no rsp_valid; a later read returns only the WAIT_RSP byte.
- With UART_MEMORY_CLIENT_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with no reply → rsp_valid and rsp_timeout pulse 8 cycles after WAIT_RSP entry; rsp_rdata=8'h00; req_ready=1.
- Assert reset_n=0 during SEND_ALO → outputs return to reset values asynchronously; no rsp_valid; the next write proceeds normally.

Source files
------------

// File: rtl/uart_memory_client_if.sv
// Bundle of request/response, UART transmit and UART receive signals for uart_memory_client.
// The slave modport is the client block; the master modport is whatever drives it (host and UART).
interface uart_memory_client_if;
  // req_valid/req_ready: a request transfers on any rising edge where both are high;
  // the initiator holds req_* stable while req_valid is high and req_ready is low.
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        received;
  logic [7:0]  rx_byte;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, tx_busy, received, rx_byte,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, transmit, tx_byte
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, tx_busy, received, rx_byte,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout, transmit, tx_byte
  );
endinterface

// File: rtl/uart_memory_client.sv
// Host-side initiator for the UART memory protocol: serializes one read/write request into UART bytes
// and returns the read reply. Optional read-reply watchdog enabled by UART_MEMORY_CLIENT_TIMEOUT_EN.
`ifndef COMMAND_WRITE
`define COMMAND_WRITE 8'h57
`endif
`ifndef COMMAND_READ
`define COMMAND_READ 8'h52
`endif

module uart_memory_client #(
  parameter logic [7:0]  CMD_WRITE      = `COMMAND_WRITE,
  parameter logic [7:0]  CMD_READ       = `COMMAND_READ,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  uart_memory_client_if.slave   bus,
  output logic [2:0]            o_dbg_state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_CMD  = 3'd1;
  localparam logic [2:0] SEND_AHI  = 3'd2;
  localparam logic [2:0] SEND_ALO  = 3'd3;
  localparam logic [2:0] SEND_DATA = 3'd4;
  localparam logic [2:0] WAIT_RSP  = 3'd5;

  logic [2:0]  r_state;
  logic        r_guard;
  logic        r_write;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_transmit;
  logic [7:0]  r_tx_byte;
  logic        r_rsp_valid;
  logic        r_rsp_timeout;
  logic [7:0]  r_rsp_rdata;
  logic [7:0]  w_tx_sel;

`ifdef UART_MEMORY_CLIENT_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        w_expired;
  assign w_expired = (r_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic        w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_tx_sel = 8'h00;
    case (r_state)
      SEND_CMD:  w_tx_sel = r_write ? CMD_WRITE : CMD_READ;
      SEND_AHI:  w_tx_sel = r_addr[15:8];
      SEND_ALO:  w_tx_sel = r_addr[7:0];
      SEND_DATA: w_tx_sel = r_wdata;
      default:   w_tx_sel = 8'h00;
    endcase
  end

  // r_guard marks "byte just issued": it blocks a second issue while the transmitter's busy
  // flag is still rising, and the state advances on the cycle it clears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_guard       <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= 16'h0000;
      r_wdata       <= 8'h00;
      r_transmit    <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= 8'h00;
`ifdef UART_MEMORY_CLIENT_TIMEOUT_EN
      r_cnt         <= 32'd0;
`endif
    end else begin
      r_transmit    <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_guard       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_state <= SEND_CMD;
          end
        end
        SEND_CMD, SEND_AHI, SEND_ALO, SEND_DATA: begin
          if (r_guard) begin
            case (r_state)
              SEND_CMD: r_state <= SEND_AHI;
              SEND_AHI: r_state <= SEND_ALO;
              SEND_ALO: r_state <= r_write ? SEND_DATA : WAIT_RSP;
              default: begin
                r_rsp_valid <= 1'b1;
                r_state     <= IDLE;
              end
            endcase
          end else if (!bus.tx_busy) begin
            r_transmit <= 1'b1;
            r_tx_byte  <= w_tx_sel;
            r_guard    <= 1'b1;
          end
        end
        WAIT_RSP: begin
          if (bus.received) begin
            r_rsp_rdata <= bus.rx_byte;
            r_rsp_valid <= 1'b1;
            r_state     <= IDLE;
`ifdef UART_MEMORY_CLIENT_TIMEOUT_EN
            r_cnt       <= 32'd0;
          end else if (w_expired) begin
            r_rsp_rdata   <= 8'h00;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= IDLE;
            r_cnt         <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.transmit    = r_transmit;
  assign bus.tx_byte     = r_tx_byte;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_uart_memory_client.sv
// Randomized scoreboard bench for uart_memory_client: expected bytes/responses are queued at issue time
// and a negedge monitor checks every transmit and rsp_valid against them, including cycle timing.
module tb_uart_memory_client;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam int TO    = 8;
  localparam int INF   = 32'h7fffffff;
  localparam int BOUND = 4000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] dbg_state;

  uart_memory_client_if bus ();

  uart_memory_client #(.CMD_WRITE(CMD_W), .CMD_READ(CMD_R), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial forever #5 clock = ~clock;
  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [8:0]  exp_tx_q[$];   // [8] = first byte of a transaction
  logic [10:0] exp_rsp_q[$];  // [10:9] kind 0=write 1=read reply 2=read timeout, [8] timeout, [7:0] rdata
  int total = 0;
  int bad = 0;
  int tx_seen = 0, tx_pushed = 0;
  int earliest = INF;
  int last_tx_cyc = 0, reply_cyc = 0;
  bit in_flight = 0;
  logic [7:0] model_rdata = 8'h00;
  bit busy_rand = 0;
  int busy_fixed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bail(input string what);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired without the expected event", what);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // ---------------- UART transmitter busy model ----------------
  initial begin
    int len;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && bus.transmit) begin
        len = busy_rand ? int'($urandom_range(0, 6)) : busy_fixed;
        if (len > 0) begin
          @(posedge clock); #1;
          bus.tx_busy = 1'b1;
          repeat (len) @(posedge clock);
          #1 bus.tx_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [8:0]  et;
    logic [10:0] er;
    logic        prev_busy;
    int          want;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        check("req_ready", bus.req_ready, (!in_flight || bus.rsp_valid));
        // a byte is due on the first slot at/after 'earliest' whose preceding cycle had tx_busy low
        if (earliest != INF && cyc >= earliest && !prev_busy)
          check("tx_due", bus.transmit, 1'b1);
        if (bus.transmit) begin
          if (exp_tx_q.size() == 0 || earliest == INF) begin
            check("tx_unexpected", bus.transmit, 1'b0);
          end else begin
            check("tx_slot", (cyc >= earliest && !prev_busy), 1'b1);
            et = exp_tx_q.pop_front();
            check("tx_byte", bus.tx_byte, et[7:0]);
            tx_seen++;
            last_tx_cyc = cyc;
            if (exp_tx_q.size() > 0 && !exp_tx_q[0][8]) earliest = cyc + 2;
            else earliest = INF;
          end
        end
        if (bus.rsp_valid) begin
          if (exp_rsp_q.size() == 0) begin
            check("rsp_unexpected", bus.rsp_valid, 1'b0);
          end else begin
            er = exp_rsp_q.pop_front();
            check("rsp_timeout", bus.rsp_timeout, er[8]);
            check("rsp_rdata", bus.rsp_rdata, er[7:0]);
            case (er[10:9])
              2'd0:    want = last_tx_cyc + 1;
              2'd1:    want = reply_cyc + 1;
              default: want = last_tx_cyc + 1 + TO;
            endcase
            check("rsp_cycle", cyc, want);
          end
          in_flight = 0;
        end
      end
      prev_busy = bus.tx_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] reply, input bit expect_timeout);
    int n;
    exp_tx_q.push_back({1'b1, (wr ? CMD_W : CMD_R)});
    exp_tx_q.push_back({1'b0, addr[15:8]});
    exp_tx_q.push_back({1'b0, addr[7:0]});
    if (wr) exp_tx_q.push_back({1'b0, wd});
    tx_pushed += wr ? 4 : 3;
    if (wr) begin
      exp_rsp_q.push_back({2'd0, 1'b0, model_rdata});
    end else if (expect_timeout) begin
      model_rdata = 8'h00;
      exp_rsp_q.push_back({2'd2, 1'b1, 8'h00});
    end else begin
      model_rdata = reply;
      exp_rsp_q.push_back({2'd1, 1'b0, reply});
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.req_ready) break;
      n++;
      if (n > BOUND) bail("req_accept");
    end
    earliest = cyc + 2;
    @(posedge clock); #1;
    in_flight = 1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 8'($urandom);
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_seen < target) begin
      @(negedge clock);
      n++;
      if (n > BOUND) bail("wait_tx");
    end
  endtask

  task automatic pulse_rx(input logic [7:0] b, input bit is_reply);
    @(posedge clock); #1;
    bus.received = 1'b1;
    bus.rx_byte  = b;
    if (is_reply) reply_cyc = cyc;
    @(posedge clock); #1;
    bus.received = 1'b0;
    bus.rx_byte  = 8'($urandom);
  endtask

  task automatic respond(input logic [7:0] b);
    wait_tx(tx_pushed);
    repeat ($urandom_range(0, 3)) @(posedge clock);
    pulse_rx(b, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_tx_q.size() != 0 || exp_rsp_q.size() != 0 || in_flight) begin
      @(negedge clock);
      n++;
      if (n > BOUND) bail("drain");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    check({tag, "_transmit"}, bus.transmit, 1'b0);
    check({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 8'h00);
    check({tag, "_state_idle"}, dbg_state, 3'd0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic       wr;
    logic [7:0] rep;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.received  = 1'b0;
    bus.rx_byte   = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    @(posedge clock); #1 reset_n = 1'b1;

    // directed write and read with an idle transmitter
    issue(1'b1, 16'h0ECD, 8'h42, 8'h00, 1'b0);
    issue(1'b0, 16'h0A10, 8'h00, 8'h44, 1'b0);
    respond(8'h44);

    // transmitter busy for 10 cycles after every byte
    busy_fixed = 10;
    issue(1'b0, 16'h0ECD, 8'h00, 8'h42, 1'b0);
    respond(8'h42);
    wait_drain();

    // stray received bytes in IDLE and in SEND_AHI are dropped
    pulse_rx(8'hAA, 1'b0);
    repeat (4) @(posedge clock);
    issue(1'b0, 16'($urandom), 8'h00, 8'h5C, 1'b0);
    wait_tx(tx_pushed - 2);
    repeat (2) @(posedge clock);
    pulse_rx(8'hAA, 1'b0);
    respond(8'h5C);
    wait_drain();

`ifdef UART_MEMORY_CLIENT_TIMEOUT_EN
    busy_fixed = 0;
    issue(1'b0, 16'h1234, 8'h00, 8'h00, 1'b1);
    wait_drain();
`endif

    // randomized back-to-back traffic with random transmitter busy lengths
    busy_rand = 1;
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom_range(0, 1));
      rep = 8'($urandom);
      issue(wr, 16'($urandom), 8'($urandom), rep, 1'b0);
      if (!wr) respond(rep);
    end
    wait_drain();

    // asynchronous reset in the middle of a write (SEND_ALO stalled on tx_busy)
    busy_rand = 0;
    busy_fixed = 4;
    issue(1'b1, 16'hBEEF, 8'h77, 8'h00, 1'b0);
    wait_tx(tx_pushed - 2);
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_tx_q.delete();
    exp_rsp_q.delete();
    tx_seen = tx_pushed;
    in_flight = 0;
    earliest = INF;
    model_rdata = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clock);

    busy_fixed = 0;
    issue(1'b1, 16'h0ECD, 8'h42, 8'h00, 1'b0);
    issue(1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b0);
    respond(8'h3C);
    wait_drain();
    repeat (5) @(posedge clock);

    check("end_tx_queue_empty", exp_tx_q.size(), 0);
    check("end_rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
